// File: rtl/control_unit.sv
// Multi-cycle controller for an RV32I subset (add, sub, addi, lw, sw); FETCH_WAIT stretches FETCH.
// Define CONTROL_UNIT_BRANCH_EN to decode B-type branches; otherwise opcode 1100011 halts as illegal.
module control_unit #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        aluZero,
    input  logic        aluLessThan,
    input  logic        aluLessThanU,
    output logic        writeEnable_Registers,
    output logic        writeEnable_DataMemory,
    output logic        muxSelect_SumVsReadData,
    output logic        muxSelect_ImmVsDataout2,
    output logic        SumOrSub,
    output logic        irLoad,
    output logic        pcWrite,
    output logic        pcSrc,
    output logic        illegalInstr,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd7
    } stateType;

    typedef enum logic [2:0] {
        I_ADD, I_SUB, I_ADDI, I_LW, I_SW, I_BRANCH, I_ILLEGAL
    } instrKind;

    localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT);

    stateType   curState, nextState;
    instrKind   kind;
    logic [31:0] ir;
    logic [2:0]  waitCnt;
    logic        running;
    logic        fetchDone;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Register and immediate fields belong to the datapath; the controller never looks at them.
    logic unusedIrFields;
    assign unusedIrFields = ^{ir[24:15], ir[11:7]};

    assign fetchDone = (waitCnt == WAIT_LAST);
    assign state     = curState;

    always_comb begin
        kind = I_ILLEGAL;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      kind = I_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) kind = I_SUB;
            end
            7'b0010011: if (funct3 == 3'b000) kind = I_ADDI;
            7'b0000011: if (funct3 == 3'b010) kind = I_LW;
            7'b0100011: if (funct3 == 3'b010) kind = I_SW;
`ifdef CONTROL_UNIT_BRANCH_EN
            7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) kind = I_BRANCH;
`endif
            default:    kind = I_ILLEGAL;
        endcase
    end

`ifdef CONTROL_UNIT_BRANCH_EN
    logic branchTaken;
    always_comb begin
        case (funct3)
            3'b000:  branchTaken = aluZero;
            3'b001:  branchTaken = !aluZero;
            3'b100:  branchTaken = aluLessThan;
            3'b101:  branchTaken = !aluLessThan;
            3'b110:  branchTaken = aluLessThanU;
            default: branchTaken = !aluLessThanU;
        endcase
    end
`else
    logic unusedAluFlags;
    assign unusedAluFlags = ^{aluZero, aluLessThan, aluLessThanU};
    assign pcSrc = 1'b0;
`endif

    // running stays low until the first clock after reset release, so that edge starts FETCH
    // instead of ending it.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= FETCH;
            ir       <= '0;
            waitCnt  <= '0;
            running  <= 1'b0;
        end else begin
            running  <= 1'b1;
            curState <= nextState;
            if (irLoad) ir <= instruction;
            waitCnt  <= (curState == FETCH && running && !fetchDone) ? waitCnt + 3'd1 : 3'd0;
        end
    end

    // NOTE: every output and nextState gets a default first, so no path can infer a latch.
    always_comb begin
        nextState               = curState;
        writeEnable_Registers   = 1'b0;
        writeEnable_DataMemory  = 1'b0;
        muxSelect_SumVsReadData = 1'b0;
        muxSelect_ImmVsDataout2 = 1'b0;
        SumOrSub                = 1'b0;
        irLoad                  = 1'b0;
        pcWrite                 = 1'b0;
        illegalInstr            = 1'b0;
`ifdef CONTROL_UNIT_BRANCH_EN
        pcSrc                   = 1'b0;
`endif

        case (curState)
            FETCH: begin
                if (running && fetchDone) begin
                    irLoad    = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE:  nextState = (kind == I_ILLEGAL) ? HALT : EXECUTE;
            EXECUTE: begin
                case (kind)
                    I_ADD, I_SUB, I_ADDI: nextState = WRITEBACK;
                    I_LW, I_SW:           nextState = MEM;
`ifdef CONTROL_UNIT_BRANCH_EN
                    I_BRANCH: begin
                        pcWrite   = 1'b1;
                        pcSrc     = branchTaken;
                        nextState = FETCH;
                    end
`endif
                    default:              nextState = HALT;
                endcase
            end
            MEM: begin
                if (kind == I_SW) begin
                    writeEnable_DataMemory = 1'b1;
                    pcWrite                = 1'b1;
                    nextState              = FETCH;
                end else begin
                    nextState = WRITEBACK;
                end
            end
            WRITEBACK: begin
                writeEnable_Registers = 1'b1;
                pcWrite               = 1'b1;
                nextState             = FETCH;
            end
            HALT:    illegalInstr = 1'b1;
            default: nextState = FETCH;
        endcase

        // Datapath selects stay stable from EXECUTE until the instruction retires.
        if (curState inside {EXECUTE, MEM, WRITEBACK}) begin
            muxSelect_ImmVsDataout2 = (kind inside {I_ADD, I_SUB, I_BRANCH});
            SumOrSub                = (kind inside {I_SUB, I_BRANCH});
            muxSelect_SumVsReadData = (kind != I_LW);
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: FETCH_WAIT=0 and FETCH_WAIT=2 instances, each compared every cycle
// against a per-instruction trace model built from the instruction's phases.
module tb_control_unit;

    typedef struct packed {
        logic       weReg;
        logic       weMem;
        logic       selSum;
        logic       selImm;
        logic       sumSub;
        logic       irLoad;
        logic       pcWrite;
        logic       pcSrc;
        logic       illegal;
        logic [2:0] st;
    } outVec;

    typedef enum {K_ADD, K_SUB, K_ADDI, K_LW, K_SW, K_BR, K_ILL} kindT;

    localparam logic [31:0] LW_X1   = 32'h0000_2083; // lw   x1,0(x0)
    localparam logic [31:0] SUB_X4  = 32'h4011_8233; // sub  x4,x3,x1
    localparam logic [31:0] SW_X3   = 32'h0030_2C23; // sw   x3,24(x0)
    localparam logic [31:0] ADD_X5  = 32'h0020_82B3; // add  x5,x1,x2
    localparam logic [31:0] ADD_X0  = 32'h0020_8033; // add  x0,x1,x2
    localparam logic [31:0] ADDI_X2 = 32'h0050_0113; // addi x2,x0,5
    localparam logic [31:0] BEQ     = 32'h0020_8463;
    localparam logic [31:0] BNE     = 32'h0020_9463;
    localparam logic [31:0] BLT     = 32'h0020_C463;
    localparam logic [31:0] BGE     = 32'h0020_D463;
    localparam logic [31:0] BLTU    = 32'h0020_E463;
    localparam logic [31:0] BGEU    = 32'h0020_F463;
    localparam logic [31:0] BAD_F3  = 32'h0020_A463; // B-type with funct3 010
    localparam logic [31:0] MUL     = 32'h0220_8233; // funct7 0000001
    localparam logic [31:0] SLLI    = 32'h0010_1093;
    localparam logic [31:0] LB      = 32'h0000_0083;
    localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstN0 = 1'b0, rstN2 = 1'b0;
    logic [31:0] instr0 = '0, instr2 = '0;
    logic        aluZero = 1'b0, aluLessThan = 1'b0, aluLessThanU = 1'b0;
    wire  [11:0] raw0, raw2;
    outVec       act0, act2;
    outVec       q0[$], q2[$], scratch[$];
    int          nCompared = 0;
    int          nFailed = 0;

    assign act0 = raw0;
    assign act2 = raw2;

    always #5 clk = ~clk;

    control_unit #(.FETCH_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rstN0), .instruction(instr0),
        .aluZero(aluZero), .aluLessThan(aluLessThan), .aluLessThanU(aluLessThanU),
        .writeEnable_Registers(raw0[11]), .writeEnable_DataMemory(raw0[10]),
        .muxSelect_SumVsReadData(raw0[9]), .muxSelect_ImmVsDataout2(raw0[8]),
        .SumOrSub(raw0[7]), .irLoad(raw0[6]), .pcWrite(raw0[5]), .pcSrc(raw0[4]),
        .illegalInstr(raw0[3]), .state(raw0[2:0])
    );

    control_unit #(.FETCH_WAIT(2)) dut2 (
        .clk(clk), .rst_n(rstN2), .instruction(instr2),
        .aluZero(aluZero), .aluLessThan(aluLessThan), .aluLessThanU(aluLessThanU),
        .writeEnable_Registers(raw2[11]), .writeEnable_DataMemory(raw2[10]),
        .muxSelect_SumVsReadData(raw2[9]), .muxSelect_ImmVsDataout2(raw2[8]),
        .SumOrSub(raw2[7]), .irLoad(raw2[6]), .pcWrite(raw2[5]), .pcSrc(raw2[4]),
        .illegalInstr(raw2[3]), .state(raw2[2:0])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic kindT classify(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
        if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
        if (op == 7'h03 && f3 == 3'd2) return K_LW;
        if (op == 7'h23 && f3 == 3'd2) return K_SW;
`ifdef CONTROL_UNIT_BRANCH_EN
        if (op == 7'h63 && !(f3 inside {3'd2, 3'd3})) return K_BR;
`endif
        return K_ILL;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            default: return !ltu;
        endcase
    endfunction

    // Builds the expected per-cycle outputs of one instruction: w+1 fetch cycles, decode, then
    // its phases; all strobes land in the final phase.
    task automatic expand(input int w, input logic [31:0] ins, input int haltCycles);
        kindT  k;
        outVec v;
        int    phases[$];
        k = classify(ins);
        scratch.delete();
        for (int i = 0; i <= w; i++) begin
            v = '0;
            v.irLoad = (i == w);
            scratch.push_back(v);
        end
        v = '0;
        v.st = 3'd1;
        scratch.push_back(v);
        if (k == K_ILL) begin
            for (int i = 0; i < haltCycles; i++) begin
                v = '0;
                v.st = 3'd7;
                v.illegal = 1'b1;
                scratch.push_back(v);
            end
        end else begin
            phases.push_back(2);
            if (k == K_LW || k == K_SW) phases.push_back(3);
            if (k inside {K_ADD, K_SUB, K_ADDI, K_LW}) phases.push_back(4);
            foreach (phases[i]) begin
                v = '0;
                v.st     = 3'(phases[i]);
                v.selImm = (k inside {K_ADD, K_SUB, K_BR});
                v.sumSub = (k inside {K_SUB, K_BR});
                v.selSum = (k != K_LW);
                if (i == phases.size() - 1) begin
                    v.pcWrite = 1'b1;
                    v.weReg   = (phases[i] == 4);
                    v.weMem   = (k == K_SW);
                    v.pcSrc   = (k == K_BR) && taken(ins[14:12], aluZero, aluLessThan, aluLessThanU);
                end
                scratch.push_back(v);
            end
        end
    endtask

    always @(negedge clk) begin : compare
        outVec e;
        if (!rstN0) check("reset_outputs0", act0, '0);
        else if (q0.size() > 0) begin
            e = q0.pop_front();
            check($sformatf("trace0_st%0d", e.st), act0, e);
        end
        if (!rstN2) check("reset_outputs2", act2, '0);
        else if (q2.size() > 0) begin
            e = q2.pop_front();
            check($sformatf("trace2_st%0d", e.st), act2, e);
        end
    end

    task automatic releaseReset(input int dut);
        @(negedge clk);
        #1;
        if (dut == 0) rstN0 = 1'b1; else rstN2 = 1'b1;
        #1;
        check(dut == 0 ? "idle_after_release0" : "idle_after_release2", dut == 0 ? act0 : act2, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset(input int dut);
        if (dut == 0) rstN0 = 1'b0; else rstN2 = 1'b0;
        #1;
        check(dut == 0 ? "halt_reset_clear0" : "halt_reset_clear2", dut == 0 ? act0 : act2, '0);
        releaseReset(dut);
    endtask

    task automatic pushInstr(input int dut, input logic [31:0] ins, input logic z, input logic lt,
                             input logic ltu, input int haltCycles);
        aluZero      = z;
        aluLessThan  = lt;
        aluLessThanU = ltu;
        if (dut == 0) begin
            instr0 = ins;
            expand(0, ins, haltCycles);
            foreach (scratch[i]) q0.push_back(scratch[i]);
        end else begin
            instr2 = ins;
            expand(2, ins, haltCycles);
            foreach (scratch[i]) q2.push_back(scratch[i]);
        end
    endtask

    task automatic drain(input int dut);
        int c;
        c = 0;
        while ((dut == 0 ? q0.size() : q2.size()) > 0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        if (c >= 200) begin
            nCompared++;
            nFailed++;
            $display("FAIL drain_timeout: dut %0d still had expected cycles after %0d clocks", dut, c);
        end
        #1;
    endtask

    task automatic runInstr(input int dut, input logic [31:0] ins, input logic z, input logic lt,
                            input logic ltu);
        pushInstr(dut, ins, z, lt, ltu, (ins == ALL_ONE) ? 20 : 3);
        drain(dut);
        if (classify(ins) == K_ILL) pulseReset(dut);
    endtask

    // Hand-derived traces that anchor the model before it judges the DUT.
    task automatic pinModel();
        aluZero = 1'b0; aluLessThan = 1'b0; aluLessThanU = 1'b0;
        expand(0, LW_X1, 3);
        check("pin_lw_len", scratch.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("pin_lw_state%0d", i), scratch[i].st, i);
            check($sformatf("pin_lw_weReg%0d", i), scratch[i].weReg, (i == 4));
        end
        check("pin_lw_last", scratch[4], 12'h824);
        expand(0, SUB_X4, 3);
        check("pin_sub_len", scratch.size(), 4);
        check("pin_sub_last", scratch[3], 12'hBA4);
        expand(0, SW_X3, 3);
        check("pin_sw_len", scratch.size(), 4);
        check("pin_sw_last", scratch[3], 12'h623);
        expand(2, ADDI_X2, 3);
        check("pin_addi_w2_len", scratch.size(), 6);
        check("pin_addi_w2_irload", scratch[2].irLoad, 1);
        check("pin_addi_w2_last", scratch[5], 12'hA24);
        expand(0, ALL_ONE, 20);
        check("pin_illegal_len", scratch.size(), 22);
        aluZero = 1'b1;
        expand(0, BEQ, 3);
`ifdef CONTROL_UNIT_BRANCH_EN
        check("pin_beq_len", scratch.size(), 3);
        check("pin_beq_last", scratch[2], 12'h3B2);
        expand(0, BNE, 3);
        check("pin_bne_last", scratch[2], 12'h3A2);
        aluZero = 1'b0; aluLessThanU = 1'b1;
        expand(0, BLTU, 3);
        check("pin_bltu_last", scratch[2], 12'h3B2);
`else
        check("pin_beq_halts", scratch[2], 12'h00F);
`endif
    endtask

    initial begin
        pinModel();

        // FETCH_WAIT = 0 instance
        releaseReset(0);
        runInstr(0, LW_X1,   1'b0, 1'b0, 1'b0);
        runInstr(0, SUB_X4,  1'b0, 1'b0, 1'b0);
        runInstr(0, SW_X3,   1'b0, 1'b0, 1'b0);
        runInstr(0, ADD_X5,  1'b0, 1'b0, 1'b0);
        runInstr(0, ADD_X0,  1'b0, 1'b0, 1'b0);
        runInstr(0, ADDI_X2, 1'b0, 1'b0, 1'b0);
        runInstr(0, BEQ,     1'b1, 1'b0, 1'b0);
        runInstr(0, BNE,     1'b1, 1'b0, 1'b0);
        runInstr(0, BLTU,    1'b0, 1'b0, 1'b1);
        runInstr(0, BLT,     1'b0, 1'b0, 1'b0);
        runInstr(0, BGE,     1'b0, 1'b0, 1'b0);
        runInstr(0, BGEU,    1'b0, 1'b1, 1'b1);
        runInstr(0, BEQ,     1'b0, 1'b1, 1'b0);
        runInstr(0, ALL_ONE, 1'b0, 1'b0, 1'b0);
        runInstr(0, MUL,     1'b0, 1'b0, 1'b0);
        runInstr(0, BAD_F3,  1'b0, 1'b0, 1'b0);
        runInstr(0, SLLI,    1'b0, 1'b0, 1'b0);
        runInstr(0, LB,      1'b0, 1'b0, 1'b0);
        runInstr(0, LW_X1,   1'b0, 1'b0, 1'b0);
        rstN0 = 1'b0;

        // FETCH_WAIT = 2 instance, including a reset landing in EXECUTE
        releaseReset(2);
        runInstr(2, ADDI_X2, 1'b0, 1'b0, 1'b0);
        pushInstr(2, ADDI_X2, 1'b0, 1'b0, 1'b0, 3);
        repeat (4) @(posedge clk);
        #2;
        check("exec_state_before_reset", act2.st, 3'd2);
        check("exec_selSum_before_reset", act2.selSum, 1'b1);
        rstN2 = 1'b0;
        q2.delete();
        #1;
        check("async_reset_outputs", act2, '0);
        releaseReset(2);
        runInstr(2, ADDI_X2, 1'b0, 1'b0, 1'b0);
        runInstr(2, LW_X1,   1'b0, 1'b0, 1'b0);
        runInstr(2, SW_X3,   1'b0, 1'b0, 1'b0);
        runInstr(2, BEQ,     1'b1, 1'b0, 1'b0);
        runInstr(2, SUB_X4,  1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
